// File: rtl/y86_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : y86_fetch_ctrl
// Brief   : Y86-64 fetch sequencer: PC ownership, imem access, field split,
//           valP/status generation and valid/ready hand-off to decode.
// Revision: 1.0
// ============================================================================
module y86_fetch_ctrl #(
    parameter int                ADDR_W    = 64,
    parameter int                MEM_LAT   = 1,
    parameter int                MEM_BYTES = 4096,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_pc,
    input  logic [79:0]       imem_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        stat,
    output logic              halted
);

    localparam logic [2:0]    c_STAT_AOK = 3'd1;
    localparam logic [2:0]    c_STAT_HLT = 3'd2;
    localparam logic [2:0]    c_STAT_ADR = 3'd3;
    localparam logic [2:0]    c_STAT_INS = 3'd4;
    localparam logic [3:0]    c_LAT      = 4'(MEM_LAT);
    localparam logic [ADDR_W:0] c_MEM_END = (ADDR_W+1)'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_out_valid;
    logic [3:0]          r_icode;
    logic [3:0]          r_ifun;
    logic [3:0]          r_ra;
    logic [3:0]          r_rb;
    logic [63:0]         r_valc;
    logic [ADDR_W-1:0]   r_valp;
    logic [ADDR_W-1:0]   r_inst_pc;
    logic [2:0]          r_stat;
    logic                r_halted;

    logic [7:0]          w_byte [10];
    logic [3:0]          w_icode;
    logic [3:0]          w_ifun;
    logic [3:0]          w_len;
    logic                w_has_regs;
    logic [3:0]          w_ra;
    logic [3:0]          w_rb;
    logic [63:0]         w_valc;
    logic                w_ifun_ok;
    logic [ADDR_W:0]     w_end;
    logic [ADDR_W-1:0]   w_valp;
    logic [2:0]          w_stat;
    logic                w_xfer;

    // byte0 sits in the top lane of the fetch window
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            w_byte[i] = imem_inst[79-8*i -: 8];
        end
    end

    assign w_icode = w_byte[0][7:4];
    assign w_ifun  = w_byte[0][3:0];

    always_comb begin
        w_len = 4'd1;
        case (w_icode)
            4'h2, 4'h6, 4'hA, 4'hB: w_len = 4'd2;
            4'h7, 4'h8:             w_len = 4'd9;
            4'h3, 4'h4, 4'h5:       w_len = 4'd10;
            default:                w_len = 4'd1;
        endcase
    end

    assign w_has_regs = (w_len == 4'd2) || (w_len == 4'd10);
    assign w_ra       = w_has_regs ? w_byte[1][7:4] : 4'hF;
    assign w_rb       = w_has_regs ? w_byte[1][3:0] : 4'hF;

    always_comb begin
        w_valc = 64'd0;
        case (w_icode)
            4'h3, 4'h4, 4'h5:
                w_valc = {w_byte[9], w_byte[8], w_byte[7], w_byte[6],
                          w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
            4'h7, 4'h8:
                w_valc = {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                          w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
            default:
                w_valc = 64'd0;
        endcase
    end

    always_comb begin
        w_ifun_ok = 1'b0;
        case (w_icode)
            4'h2, 4'h7: w_ifun_ok = (w_ifun <= 4'd6);
            4'h6:       w_ifun_ok = (w_ifun <= 4'd3);
            default:    w_ifun_ok = (w_ifun == 4'd0);
        endcase
    end

    // one extra bit so an instruction straddling the top of memory is caught
    assign w_end  = {1'b0, r_pc} + {{(ADDR_W-3){1'b0}}, w_len};
    assign w_valp = r_pc + {{(ADDR_W-4){1'b0}}, w_len};

    always_comb begin
        if (w_end > c_MEM_END) begin
            w_stat = c_STAT_ADR;
        end else if (w_icode > 4'hB) begin
            w_stat = c_STAT_INS;
        end else if (!w_ifun_ok) begin
            w_stat = c_STAT_INS;
        end else if (w_icode == 4'h0) begin
            w_stat = c_STAT_HLT;
        end else begin
            w_stat = c_STAT_AOK;
        end
    end

    assign w_xfer = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_cnt       <= 4'd0;
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_icode     <= 4'h0;
            r_ifun      <= 4'h0;
            r_ra        <= 4'hF;
            r_rb        <= 4'hF;
            r_valc      <= 64'd0;
            r_valp      <= '0;
            r_inst_pc   <= '0;
            r_stat      <= c_STAT_AOK;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end else begin
                        r_cnt   <= c_LAT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_pc;
                        r_state <= S_REQ;
                    end else if (r_cnt == 4'd1) begin
                        r_icode     <= w_icode;
                        r_ifun      <= w_ifun;
                        r_ra        <= w_ra;
                        r_rb        <= w_rb;
                        r_valc      <= w_valc;
                        r_valp      <= w_valp;
                        r_inst_pc   <= r_pc;
                        r_stat      <= w_stat;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_OUT: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        if (r_stat != c_STAT_AOK) begin
                            r_pc     <= r_valp;
                            r_halted <= 1'b1;
                            r_state  <= S_STOP;
                        end else begin
                            r_pc    <= redirect_valid ? redirect_pc : r_valp;
                            r_state <= S_REQ;
                        end
                    end else if (redirect_valid) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= redirect_pc;
                        r_state     <= S_REQ;
                    end
                end
                S_STOP: begin
                    r_out_valid <= 1'b0;
                    r_halted    <= 1'b1;
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    assign imem_pc   = r_pc;
    assign out_valid = r_out_valid;
    assign icode     = r_icode;
    assign ifun      = r_ifun;
    assign rA        = r_ra;
    assign rB        = r_rb;
    assign valC      = r_valc;
    assign valP      = r_valp;
    assign pc        = r_inst_pc;
    assign stat      = r_stat;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_y86_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_y86_fetch_ctrl
// Brief   : Scoreboard bench for y86_fetch_ctrl with a byte-array imem model.
// Revision: 1.0
// ============================================================================
module tb_y86_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [63:0] imem_pc;
    logic [79:0] imem_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc;
    logic [2:0]  stat;
    logic        halted;

    y86_fetch_ctrl #(
        .ADDR_W   (64),
        .MEM_LAT  (1),
        .MEM_BYTES(4096),
        .RESET_PC (64'd0)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_pc       (imem_pc),
        .imem_inst     (imem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .icode         (icode),
        .ifun          (ifun),
        .rA            (rA),
        .rB            (rB),
        .valC          (valC),
        .valP          (valP),
        .pc            (pc),
        .stat          (stat),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [4096];

    always_comb begin
        imem_inst = 80'd0;
        for (int i = 0; i < 10; i++) begin
            logic [63:0] a;
            a = imem_pc + 64'(i);
            if (a < 64'd4096) imem_inst[79-8*i -: 8] = mem[a[11:0]];
        end
    end

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] pc;
        logic [2:0]  stat;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic push(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                        input logic [63:0] p, input logic [2:0] st);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.pc = p; e.stat = st;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted instruction is compared against the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected actual pc=%h icode=%h required=none", pc, icode);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_icode", 64'(icode), 64'(mon_e.icode));
                chk("sb_ifun",  64'(ifun),  64'(mon_e.ifun));
                chk("sb_rA",    64'(rA),    64'(mon_e.ra));
                chk("sb_rB",    64'(rB),    64'(mon_e.rb));
                chk("sb_valC",  valC,       mon_e.valc);
                chk("sb_valP",  valP,       mon_e.valp);
                chk("sb_pc",    pc,         mon_e.pc);
                chk("sb_stat",  64'(stat),  64'(mon_e.stat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (out_valid) return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout actual=out_valid_low required=out_valid_high", nm);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        exp_q.delete();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        step();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_imem_pc"},   imem_pc,          64'd0);
        chk({nm, "_out_valid"}, 64'(out_valid),   64'd0);
        chk({nm, "_fields"},    64'({icode, ifun, rA, rB}), 64'h00FF);
        chk({nm, "_valC"},      valC,             64'd0);
        chk({nm, "_valP"},      valP,             64'd0);
        chk({nm, "_pc"},        pc,               64'd0);
        chk({nm, "_stat"},      64'(stat),        64'd1);
        chk({nm, "_halted"},    64'(halted),      64'd0);
    endtask

    task automatic load(input int base, input logic [7:0] b [10], input int n);
        for (int i = 0; i < n; i++) mem[base+i] = b[i];
    endtask

    initial begin
        logic [7:0] b [10];
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0;

        // Scenario 1: irmovq at 0, then halt at 10
        do_reset();
        chk_reset_vals("rst1");
        b = '{8'h30, 8'hF0, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        load(0, b, 10);
        mem[10] = 8'h00;
        push(4'h3, 4'h0, 4'hF, 4'h0, 64'h0123456789ABCDEF, 64'd10, 64'd0, 3'd1);
        push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 64'd10, 3'd2);
        out_ready = 1'b1;
        rst = 1'b0;
        step();
        chk("s1_valid_c2", 64'(out_valid), 64'd0);
        step();
        chk("s1_valid_c3", 64'(out_valid), 64'd1);
        step();
        chk("s1_next_imem_pc", imem_pc, 64'd10);
        wait_valid("s1_halt");
        step();
        chk("s1_halted", 64'(halted), 64'd1);
        chk("s1_stop_valid", 64'(out_valid), 64'd0);
        step(); step(); step();
        chk("s1_frozen_pc", imem_pc, 64'd11);
        chk("s1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Scenario 2: addq held, jmp with redirect, halt at 0x40, redirect in STOP
        do_reset();
        b = '{8'h60, 8'h23, 8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(0, b, 10);
        mem[10] = 8'h00;
        mem[11] = 8'h10;
        mem[64] = 8'h00;
        push(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd2, 64'd0, 3'd1);
        push(4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'd11, 64'd2, 3'd1);
        push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 64'h40, 3'd2);
        out_ready = 1'b0;
        rst = 1'b0;
        wait_valid("s2_addq");
        for (int k = 0; k < 3; k++) begin
            chk("s2_hold_valid", 64'(out_valid), 64'd1);
            chk("s2_hold_fields", 64'({icode, ifun, rA, rB}), 64'h6023);
            chk("s2_hold_valP", valP, 64'd2);
            step();
        end
        out_ready = 1'b1;
        step();
        wait_valid("s2_jmp");
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        step();
        redirect_valid = 1'b0;
        chk("s2_redirect_pc", imem_pc, 64'h40);
        wait_valid("s2_halt");
        step();
        chk("s2_halted", 64'(halted), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step(); step(); step();
        chk("s2_stop_ignores_redirect", imem_pc, 64'h41);
        chk("s2_stop_valid", 64'(out_valid), 64'd0);
        redirect_valid = 1'b0;
        chk("s2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Scenario 3: redirect during WAIT aborts the nop at 0
        do_reset();
        mem[0]    = 8'h10;
        mem[1]    = 8'h00;
        mem[128]  = 8'h00;
        push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h81, 64'h80, 3'd2);
        out_ready = 1'b1;
        rst = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        step();
        redirect_valid = 1'b0;
        chk("s3_abort_pc", imem_pc, 64'h80);
        chk("s3_abort_valid", 64'(out_valid), 64'd0);
        wait_valid("s3_halt");
        step();
        chk("s3_halted", 64'(halted), 64'd1);
        chk("s3_sb_empty", 64'(exp_q.size()), 64'd0);

        // Scenario 4: invalid opcode 0xC0
        do_reset();
        mem[0] = 8'hC0;
        mem[1] = 8'h10;
        push(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 64'd0, 3'd4);
        rst = 1'b0;
        wait_valid("s4_ins");
        chk("s4_halted_pre", 64'(halted), 64'd0);
        step();
        chk("s4_halted_post", 64'(halted), 64'd1);
        chk("s4_valid_post", 64'(out_valid), 64'd0);
        step(); step();
        chk("s4_frozen_pc", imem_pc, 64'd1);
        chk("s4_sb_empty", 64'(exp_q.size()), 64'd0);

        // Scenario 5: irmovq straddling the end of memory -> ADR
        do_reset();
        mem[4091] = 8'h30; mem[4092] = 8'hF2; mem[4093] = 8'h11;
        mem[4094] = 8'h22; mem[4095] = 8'h33;
        push(4'h3, 4'h0, 4'hF, 4'h2, 64'h332211, 64'd4101, 64'd4091, 3'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 64'd4091;
        rst = 1'b0;
        step();
        redirect_valid = 1'b0;
        chk("s5_req_redirect", imem_pc, 64'd4091);
        wait_valid("s5_adr");
        step();
        chk("s5_halted", 64'(halted), 64'd1);
        chk("s5_sb_empty", 64'(exp_q.size()), 64'd0);

        // Scenario 6: asynchronous reset mid-WAIT, then a clean refetch
        do_reset();
        b = '{8'h30, 8'hF0, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        load(0, b, 10);
        mem[0] = 8'h30; mem[1] = 8'hF4;
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        step();
        chk("s6_no_valid", 64'(out_valid), 64'd0);
        push(4'h3, 4'h0, 4'hF, 4'h4, 64'h0123456789ABCDEF, 64'd10, 64'd0, 3'd1);
        rst = 1'b0;
        wait_valid("s6_refetch");
        step();
        chk("s6_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
